tilemap_arbiter: RTL
====================

TILEMAP_ARBITER -- requirements
Module: tilemap_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, tilemap RAM address width (256 entries, 16x16 tile grid).
REQ-002 Parameter: DATA_W, default 8, tile index width.
REQ-003 Parameter: WBUF_DEPTH, default 4, CPU write-buffer entries (power of two).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 vid_req  input  1  video tile-index fetch request, single-cycle pulse.
REQ-007 vid_addr  input  ADDR_W  video fetch address (col + 16*row).
REQ-008 vid_data  output  DATA_W  fetched tile index.
REQ-009 vid_valid  output  1  vid_data valid.
REQ-010 cpu_wr_req  input  1  CPU write request, held until acked.
REQ-011 cpu_wr_addr  input  ADDR_W  CPU write address.
REQ-012 cpu_wr_data  input  DATA_W  CPU write data.
REQ-013 cpu_wr_ack  output  1  write accepted this cycle.
REQ-014 cpu_rd_req  input  1  CPU read request, held until cpu_rd_valid.
REQ-015 cpu_rd_addr  input  ADDR_W  CPU read address.
REQ-016 cpu_rd_data  output  DATA_W  CPU read data.
REQ-017 cpu_rd_valid  output  1  cpu_rd_data valid, one-cycle pulse.
REQ-018 ram_addr, ram_we, ram_wdata  output  ADDR_W/1/DATA_W  single-port RAM controls, registered.
REQ-019 ram_rdata  input  DATA_W  RAM read data, 1-cycle latency after ram_addr registered.
REQ-020 wbuf_full  output  1  write buffer full status.

Function
REQ-021 One RAM slot per cycle; per-cycle grant priority fixed: video > buffered write > CPU read.
REQ-022 Grant FSM states: IDLE, VID, WR, RD; next state is chosen each cycle from pending requests by REQ-021; IDLE when none pending.
REQ-023 vid_req grant is same cycle (registered to RAM next edge); vid_valid asserts exactly 2 cycles after vid_req, vid_data = RAM content at vid_addr.
REQ-024 Video requests never stall and never dropped; back-to-back vid_req every cycle serviced with 2-cycle latency each.
REQ-025 cpu_wr_ack = cpu_wr_req && !wbuf_full; acked entry pushed into FIFO same edge.
REQ-026 FIFO head written to RAM in a WR slot; pop on grant; order preserved.
REQ-027 Simultaneous push and pop when full: pop frees entry, but ack still gated by wbuf_full of current cycle (no same-cycle pass-through).
REQ-028 CPU read served only when FIFO empty and no vid_req (read-after-write coherent); cpu_rd_valid 2 cycles after RD grant.
REQ-029 CPU read pending while blocked: hold request; no timeout; starvation permitted only while video or writes active.
REQ-030 FIFO pointers wrap modulo WBUF_DEPTH; count width log2(WBUF_DEPTH)+1.
REQ-031 ram_we high only in WR-granted cycles; ram_addr/ram_wdata hold last value otherwise.

Reset
REQ-032 On rst: FSM IDLE, FIFO empty, vid_valid=0, cpu_rd_valid=0, cpu_wr_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, vid_data=0, cpu_rd_data=0, wbuf_full=0.
REQ-033 Reset mid-operation discards buffered writes and in-flight reads; no valid pulse issued for them.

Configuration
REQ-034 Macro TILEMAP_WBUF_EN: defined -> write FIFO per REQ-025..027; undefined -> no FIFO, cpu_wr_ack asserts only in the cycle a direct WR slot is granted (after video), wbuf_full tied 0.

Verification
REQ-035 vid_req addr 0x23 with RAM[0x23]=0x5A -> vid_valid at +2 cycles, vid_data=0x5A.
REQ-036 Five CPU writes back-to-back, vid_req held every cycle -> 4 acked, wbuf_full=1, fifth waits; after vid stops, writes land in order, fifth acked.
REQ-037 Write 0x11 to 0x40 then read 0x40 next cycle -> cpu_rd_data=0x11 (read waits for FIFO drain).
REQ-038 vid_req and cpu_wr_req same cycle -> ram_we=0 that slot, write in next free slot, vid latency unchanged.
REQ-039 rst asserted with 3 buffered writes -> RAM unchanged at those addresses, wbuf_full=0, all outputs 0 next cycle.
REQ-040 TILEMAP_WBUF_EN undefined, write with no video -> cpu_wr_ack same cycle as ram_we=1.

Source files
------------

// File: rtl/tilemap_arbiter.sv
// Tilemap RAM arbiter: video fetch > buffered CPU write > CPU read, one RAM slot per cycle.
// Define TILEMAP_WBUF_EN to enable the CPU write FIFO; without it writes go straight to RAM.
module tilemap_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ack,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wbuf_full
);

  typedef enum logic [1:0] {IDLE, VID, WR, RD} state_t;

  state_t            state, next_state;
  logic              vid_v_q, rd_v_q;
  logic              wr_pend, rd_pend, wbuf_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

`ifdef TILEMAP_WBUF_EN
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  // ack is gated by the registered count only, so a pop never frees a slot for the same cycle
  assign wbuf_full  = (count == CW'(WBUF_DEPTH));
  assign wbuf_empty = (count == '0);
  assign cpu_wr_ack = cpu_wr_req && !wbuf_full && !rst;
  assign push       = cpu_wr_ack;
  assign pop        = (next_state == WR);
  assign wr_pend    = !wbuf_empty;
  assign head_addr  = fifo_addr[rptr];
  assign head_data  = fifo_data[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= cpu_wr_addr;
      fifo_data[wptr] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
`else
  logic wr_ack_q;

  // ack lines up with ram_we; blocking re-grant in that cycle keeps the held request from writing twice
  assign cpu_wr_ack = wr_ack_q;
  assign wbuf_full  = (WBUF_DEPTH < 1);
  assign wbuf_empty = 1'b1;
  assign wr_pend    = cpu_wr_req && !wr_ack_q;
  assign head_addr  = cpu_wr_addr;
  assign head_data  = cpu_wr_data;

  always_ff @(posedge clk) begin
    if (rst) wr_ack_q <= 1'b0;
    else     wr_ack_q <= (next_state == WR);
  end
`endif

  // a read waits for the buffer to drain and for its own previous access to retire
  assign rd_pend = cpu_rd_req && !vid_req && wbuf_empty && !cpu_wr_ack &&
                   (state != RD) && !rd_v_q;

  always_comb begin
    next_state = IDLE;
    if (vid_req)      next_state = VID;
    else if (wr_pend) next_state = WR;
    else if (rd_pend) next_state = RD;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (next_state)
        VID: ram_addr <= vid_addr;
        WR: begin
          ram_addr  <= head_addr;
          ram_wdata <= head_data;
        end
        RD: ram_addr <= cpu_rd_addr;
        default: ;
      endcase
    end
  end

  // state is the first pipe stage; RAM data returns one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_v_q <= 1'b0;
      rd_v_q  <= 1'b0;
    end else begin
      vid_v_q <= (state == VID);
      rd_v_q  <= (state == RD);
    end
  end

  assign ram_we       = (state == WR);
  assign vid_valid    = vid_v_q;
  assign vid_data     = vid_v_q ? ram_rdata : '0;
  assign cpu_rd_valid = rd_v_q;
  assign cpu_rd_data  = rd_v_q ? ram_rdata : '0;

endmodule
